// File: rtl/fsk_bit_decoder.sv
// rtl/fsk_bit_decoder.sv - FSK bit-window decider and LSB-first byte packer
// Times bit windows, judges the analyzer tone counts, restarts the analyzer and emits bytes.
module fsk_bit_decoder #(
  parameter int CLOCK_FREQUENCY   = 50000000,
  parameter int BIT_RATE          = 1000,
  parameter int THRESHOLD_PERCENT = 25
) (
  input  logic        clock,
  input  logic        clear,
  input  logic        enable,
  input  logic [31:0] f0_value,
  input  logic [31:0] f1_value,
  output logic        analyzer_enable,
  output logic        analyzer_clear,
  output logic [7:0]  data_out,
  output logic        data_valid,
  input  logic        data_ready,
  output logic        overflow,
  output logic [15:0] erasure_count
);

  localparam int BIT_TICKS = CLOCK_FREQUENCY / BIT_RATE;
  localparam int CW        = $clog2(BIT_TICKS);
  localparam logic [CW-1:0] LAST_TICK = CW'(BIT_TICKS - 1);
  localparam logic [CW-1:0] RESUME_TICK = CW'(2);
  localparam logic [47:0] LIMIT = 48'(THRESHOLD_PERCENT) * 48'(BIT_TICKS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACQUIRE,
    S_DECIDE,
    S_CLR
  } state_t;

  state_t         state, state_next;
  logic [CW-1:0]  win_cnt, win_cnt_next;
  logic [2:0]     bit_cnt;
  logic [7:0]     shift_reg;
  logic [7:0]     shift_set;
  logic           abort;

  logic [31:0]    winner;
  logic [47:0]    winner_scaled;
  logic           tie;
  logic           bit_ok;
  logic           bit_val;
  logic           byte_done;
  logic           byte_load;

  always_comb begin
    state_next   = state;
    win_cnt_next = win_cnt;
    abort        = 1'b0;
    case (state)
      S_IDLE: begin
        if (enable) begin
          state_next   = S_ACQUIRE;
          win_cnt_next = '0;
        end
      end
      S_ACQUIRE: begin
        if (!enable) begin
          state_next = S_CLR;
          abort      = 1'b1;
        end else if (win_cnt == LAST_TICK) begin
          state_next = S_DECIDE;
        end else begin
          win_cnt_next = win_cnt + CW'(1);
        end
      end
      S_DECIDE: begin
        state_next = S_CLR;
      end
      S_CLR: begin
        // Resume at 2 so DECIDE + CLR fit inside one BIT_TICKS period.
        if (enable) begin
          state_next   = S_ACQUIRE;
          win_cnt_next = RESUME_TICK;
        end else begin
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    winner        = (f1_value > f0_value) ? f1_value : f0_value;
    tie           = (f1_value == f0_value);
    winner_scaled = {16'd0, winner} * 48'd100;
    bit_ok        = !tie && (winner_scaled >= LIMIT);
    bit_val       = (f1_value > f0_value);
    shift_set          = shift_reg;
    shift_set[bit_cnt] = bit_val;
    byte_done     = (state == S_DECIDE) && bit_ok && (bit_cnt == 3'd7);
    byte_load     = byte_done && (!data_valid || data_ready);
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state           <= S_IDLE;
      win_cnt         <= '0;
      analyzer_enable <= 1'b0;
      analyzer_clear  <= 1'b0;
    end else begin
      state           <= state_next;
      win_cnt         <= win_cnt_next;
      analyzer_enable <= (state_next == S_ACQUIRE);
      analyzer_clear  <= (state_next == S_ACQUIRE) || (state_next == S_DECIDE);
    end
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      bit_cnt       <= '0;
      shift_reg     <= '0;
      data_out      <= '0;
      data_valid    <= 1'b0;
      overflow      <= 1'b0;
      erasure_count <= '0;
    end else begin
      data_valid <= byte_load || (data_valid && !data_ready);
      if (byte_load)
        data_out <= shift_set;
      if (state == S_DECIDE) begin
        if (bit_ok) begin
          if (byte_done) begin
            bit_cnt   <= '0;
            shift_reg <= '0;
            if (!byte_load)
              overflow <= 1'b1;
          end else begin
            bit_cnt   <= bit_cnt + 3'd1;
            shift_reg <= shift_set;
          end
        end else begin
          // An erased bit breaks byte framing, so restart the byte.
          bit_cnt   <= '0;
          shift_reg <= '0;
          if (erasure_count != 16'hFFFF)
            erasure_count <= erasure_count + 16'd1;
        end
      end else if (abort) begin
        bit_cnt   <= '0;
        shift_reg <= '0;
      end
    end
  end

endmodule

// File: tb/tb_fsk_bit_decoder.sv
// tb/tb_fsk_bit_decoder.sv - directed self-checking bench for fsk_bit_decoder
module tb_fsk_bit_decoder;

  logic        clock = 1'b0;
  logic        clear;
  logic        enable;
  logic [31:0] f0_value;
  logic [31:0] f1_value;
  logic        analyzer_enable;
  logic        analyzer_clear;
  logic [7:0]  data_out;
  logic        data_valid;
  logic        data_ready;
  logic        overflow;
  logic [15:0] erasure_count;

  int n_cmp = 0;
  int n_err = 0;

  fsk_bit_decoder #(
    .CLOCK_FREQUENCY  (1000),
    .BIT_RATE         (100),
    .THRESHOLD_PERCENT(50)
  ) dut (
    .clock          (clock),
    .clear          (clear),
    .enable         (enable),
    .f0_value       (f0_value),
    .f1_value       (f1_value),
    .analyzer_enable(analyzer_enable),
    .analyzer_clear (analyzer_clear),
    .data_out       (data_out),
    .data_valid     (data_valid),
    .data_ready     (data_ready),
    .overflow       (overflow),
    .erasure_count  (erasure_count)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Call at a negedge; returns at the negedge inside the CLR cycle ending this window.
  task automatic run_window(input logic [31:0] a0, input logic [31:0] a1,
                            output int lo, output int hi);
    f0_value = a0;
    f1_value = a1;
    lo = 0;
    hi = 0;
    while (analyzer_clear == 1'b0 && lo < 100) begin
      @(negedge clock);
      lo++;
    end
    while (analyzer_clear == 1'b1 && hi < 100) begin
      @(negedge clock);
      hi++;
    end
    if (lo >= 100 || hi >= 100)
      check("window_timeout", lo + hi, 0);
  endtask

  task automatic send_byte(input logic [7:0] b);
    int lo, hi;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) run_window(32'd0, 32'd6, lo, hi);
      else      run_window(32'd6, 32'd0, lo, hi);
    end
  endtask

  initial begin
    int lo, hi, guard;
    logic [7:0] pattern;
    clear      = 1'b0;
    enable     = 1'b0;
    data_ready = 1'b0;
    f0_value   = '0;
    f1_value   = '0;
    repeat (3) @(negedge clock);
    check("rst_aen",  analyzer_enable, 0);
    check("rst_aclr", analyzer_clear, 0);
    check("rst_dv",   data_valid, 0);
    check("rst_dout", data_out, 0);
    check("rst_ovf",  overflow, 0);
    check("rst_ec",   erasure_count, 0);
    clear = 1'b1;
    @(negedge clock);
    check("idle_aclr", analyzer_clear, 0);

    // Clean byte 0xA5 with one-cycle clear pulse every 10 cycles
    enable     = 1'b1;
    data_ready = 1'b1;
    pattern    = 8'hA5;
    for (int i = 0; i < 8; i++) begin
      if (pattern[i]) run_window(32'd0, 32'd6, lo, hi);
      else            run_window(32'd6, 32'd0, lo, hi);
      if (i == 0) begin
        check("first_hi", hi, 11);
      end else begin
        check("period_lo", lo, 1);
        check("period_hi", hi, 9);
      end
    end
    check("a5_dv",   data_valid, 1);
    check("a5_dout", data_out, 32'hA5);
    @(negedge clock);
    check("a5_dv_drop", data_valid, 0);
    check("acq_aen",    analyzer_enable, 1);

    // Threshold edges and tie
    run_window(32'd0, 32'd5, lo, hi);
    check("thr5_ec", erasure_count, 0);
    run_window(32'd0, 32'd4, lo, hi);
    check("thr4_ec", erasure_count, 1);
    run_window(32'd7, 32'd7, lo, hi);
    check("tie_ec", erasure_count, 2);
    send_byte(8'h5A);
    check("resync_dv",   data_valid, 1);
    check("resync_dout", data_out, 32'h5A);
    @(negedge clock);
    check("resync_drop", data_valid, 0);

    // Backpressure across two bytes
    data_ready = 1'b0;
    send_byte(8'h3C);
    check("bp1_dv",   data_valid, 1);
    check("bp1_dout", data_out, 32'h3C);
    check("bp1_ovf",  overflow, 0);
    send_byte(8'hFF);
    check("bp2_dv",   data_valid, 1);
    check("bp2_dout", data_out, 32'h3C);
    check("bp2_ovf",  overflow, 1);
    data_ready = 1'b1;
    @(negedge clock);
    check("bp_xfer_dv", data_valid, 0);
    @(negedge clock);
    check("bp_after_dv", data_valid, 0);
    check("bp_ovf_sticky", overflow, 1);

    // Enable drop mid-window after three partial bits
    run_window(32'd0, 32'd6, lo, hi);
    run_window(32'd0, 32'd6, lo, hi);
    run_window(32'd6, 32'd0, lo, hi);
    f0_value = 32'd7;
    f1_value = 32'd7;
    repeat (3) @(negedge clock);
    enable = 1'b0;
    @(negedge clock);
    check("abort_aclr", analyzer_clear, 0);
    check("abort_aen",  analyzer_enable, 0);
    repeat (12) @(negedge clock);
    check("idle_aclr2", analyzer_clear, 0);
    check("abort_ec",   erasure_count, 2);
    check("abort_dv",   data_valid, 0);
    enable = 1'b1;
    send_byte(8'h96);
    check("reen_dv",   data_valid, 1);
    check("reen_dout", data_out, 32'h96);

    // Async reset inside DECIDE with a pending byte
    data_ready = 1'b0;
    guard = 0;
    @(negedge clock);
    while (!(analyzer_enable == 1'b0 && analyzer_clear == 1'b1) && guard < 40) begin
      @(negedge clock);
      guard++;
    end
    if (guard >= 40) check("decide_timeout", guard, 0);
    check("pre_rst_dv", data_valid, 1);
    clear = 1'b0;
    #1;
    check("arst_dv",   data_valid, 0);
    check("arst_ovf",  overflow, 0);
    check("arst_ec",   erasure_count, 0);
    check("arst_aclr", analyzer_clear, 0);
    check("arst_dout", data_out, 0);
    @(negedge clock);
    clear      = 1'b1;
    data_ready = 1'b1;
    @(negedge clock);

    // Saturation from a preloaded count
    force dut.erasure_count = 16'hFFFE;
    #1;
    release dut.erasure_count;
    run_window(32'd7, 32'd7, lo, hi);
    check("sat_1", erasure_count, 32'hFFFF);
    run_window(32'd0, 32'd1, lo, hi);
    run_window(32'd3, 32'd3, lo, hi);
    check("sat_hold", erasure_count, 32'hFFFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
